// File: rtl/if_id_reg_if.sv
// Fetch-to-decode handshake bundle for if_id_reg; slave is the buffer's view, master the surroundings.
// id_adel exists only when IFID_ADEL_EN is defined.
interface if_id_reg_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        id_ready;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
`ifdef IFID_ADEL_EN
  logic        id_adel;

  modport slave (
    input  if_valid, if_pc, if_pc4, if_inst, id_ready, flush,
    output if_ready, id_valid, id_pc, id_pc4, id_inst, id_adel
  );
  modport master (
    output if_valid, if_pc, if_pc4, if_inst, id_ready, flush,
    input  if_ready, id_valid, id_pc, id_pc4, id_inst, id_adel
  );
`else
  modport slave (
    input  if_valid, if_pc, if_pc4, if_inst, id_ready, flush,
    output if_ready, id_valid, id_pc, id_pc4, id_inst
  );
  modport master (
    output if_valid, if_pc, if_pc4, if_inst, id_ready, flush,
    input  if_ready, id_valid, id_pc, id_pc4, id_inst
  );
`endif
endinterface

// File: rtl/if_id_reg.sv
// Two-entry IF/ID skid FIFO: a push is visible the cycle after it lands, if_ready drops only when both slots are full.
// Optional IFID_ADEL_EN stores and forwards a misaligned-fetch flag with each entry.
module if_id_reg (
  input  logic       clk,
  input  logic       resetn,
  if_id_reg_if.slave bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
`ifdef IFID_ADEL_EN
    logic        adel;
`endif
  } entry_t;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  entry_t     wr_entry;
  entry_t     head;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       not_full, not_empty, push, pop;

  // Status comes only from registered count, keeping if_* and id_* free of combinational coupling.
  assign not_full  = (count_q != 2'd2);
  assign not_empty = (count_q != 2'd0);
  assign push      = bus.if_valid && not_full && !bus.flush;
  assign pop       = not_empty && bus.id_ready && !bus.flush;

  always_comb begin
    wr_entry      = '0;
    wr_entry.pc   = bus.if_pc;
    wr_entry.pc4  = bus.if_pc4;
    wr_entry.inst = bus.if_inst;
`ifdef IFID_ADEL_EN
    wr_entry.adel = (bus.if_pc[1:0] != 2'b00);
`endif
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      mem_d[0] = '0;
      mem_d[1] = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head         = not_empty ? mem_q[rd_ptr_q] : '0;
  assign bus.if_ready = not_full;
  assign bus.id_valid = not_empty;
  assign bus.id_pc    = head.pc;
  assign bus.id_pc4   = head.pc4;
  assign bus.id_inst  = head.inst;
`ifdef IFID_ADEL_EN
  assign bus.id_adel  = head.adel;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: directed scenarios plus random traffic against a queue-based model, scoreboarded by a monitor.
module tb_if_id_reg;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        adel;
  } ment_t;

  logic  clk;
  logic  resetn;
  ment_t model[$];
  ment_t exp_q[$];
  logic  exp_if_ready;
  logic  exp_id_valid;
  int    n_checks;
  int    n_pass;

  if_id_reg_if bus ();

  if_id_reg dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endfunction

  // One cycle of stimulus; the model predicts the effect of the coming edge at FIFO-queue level.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    ment_t e;
    @(posedge clk);
    #1;
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_pc4   = pc + 32'd4;
    bus.if_inst  = inst;
    bus.id_ready = rdy;
    bus.flush    = fl;
    exp_if_ready = (model.size() < 2);
    exp_id_valid = (model.size() != 0);
    if (fl) begin
      model.delete();
    end else begin
      if (exp_id_valid && rdy) begin
        exp_q.push_back(model[0]);
        void'(model.pop_front());
      end
      if (v && exp_if_ready) begin
        e.pc   = pc;
        e.pc4  = pc + 32'd4;
        e.inst = inst;
        e.adel = (pc[1:0] != 2'b00);
        model.push_back(e);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn       = 1'b0;
    bus.if_valid = 1'b0;
    bus.id_ready = 1'b0;
    bus.flush    = 1'b0;
    #1;
    check("rst_id_valid", {127'b0, bus.id_valid}, 128'd0);
    check("rst_if_ready", {127'b0, bus.if_ready}, 128'd1);
    check("rst_id_fields", {32'b0, bus.id_pc, bus.id_pc4, bus.id_inst}, 128'd0);
    model.delete();
    exp_if_ready = 1'b1;
    exp_id_valid = 1'b0;
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: samples mid-cycle, checks status and pops the scoreboard on each decode handshake.
  initial begin
    ment_t e;
    forever begin
      @(negedge clk);
      check("if_ready", {127'b0, bus.if_ready}, {127'b0, exp_if_ready});
      check("id_valid", {127'b0, bus.id_valid}, {127'b0, exp_id_valid});
      if (!bus.id_valid)
        check("idle_zero", {32'b0, bus.id_pc, bus.id_pc4, bus.id_inst}, 128'd0);
      if (bus.id_valid && bus.id_ready && !bus.flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", {96'b0, bus.id_pc}, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", {96'b0, bus.id_pc}, {96'b0, e.pc});
          check("pop_pc4", {96'b0, bus.id_pc4}, {96'b0, e.pc4});
          check("pop_inst", {96'b0, bus.id_inst}, {96'b0, e.inst});
`ifdef IFID_ADEL_EN
          check("pop_adel", {127'b0, bus.id_adel}, {127'b0, e.adel});
`endif
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    n_checks     = 0;
    n_pass       = 0;
    exp_if_ready = 1'b1;
    exp_id_valid = 1'b0;
    resetn       = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_pc4   = '0;
    bus.if_inst  = '0;
    bus.id_ready = 1'b0;
    bus.flush    = 1'b0;
    #2;
    check("init_id_valid", {127'b0, bus.id_valid}, 128'd0);
    check("init_if_ready", {127'b0, bus.if_ready}, 128'd1);
    check("init_fields", {32'b0, bus.id_pc, bus.id_pc4, bus.id_inst}, 128'd0);
    #5;
    resetn = 1'b1;

    // First fetch appears one cycle later.
    drive(1, 32'hBFC00000, 32'h24080001, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    drive(0, 32'h0, 32'h0, 0, 0);

    // Fill both slots, a third push is refused, then drain in order.
    drive(1, 32'hBFC00000, 32'h11111111, 0, 0);
    drive(1, 32'hBFC00004, 32'h22222222, 0, 0);
    drive(1, 32'hBFC00008, 32'h33333333, 0, 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);

    // Flush beats a simultaneous push and pop while full.
    drive(1, 32'hBFC00010, 32'h44444444, 0, 0);
    drive(1, 32'hBFC00014, 32'h55555555, 0, 0);
    drive(1, 32'hBFC00018, 32'h66666666, 1, 1);
    drive(0, 32'h0, 32'h0, 0, 0);

    // Push+pop at count 1, then sustained streaming.
    drive(1, 32'hBFC00000, 32'h77777777, 0, 0);
    drive(1, 32'hBFC00008, 32'h88888888, 1, 0);
    for (int i = 0; i < 8; i++)
      drive(1, 32'hBFC00100 + 32'(i * 4), 32'hA0000000 + 32'(i), 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);

    // Asynchronous reset while full, then a lone push.
    drive(1, 32'hBFC00020, 32'h99999999, 0, 0);
    drive(1, 32'hBFC00024, 32'hAAAAAAAA, 0, 0);
    drive(0, 32'h0, 32'h0, 0, 0);
    do_reset();
    drive(1, 32'hBFC00030, 32'hBBBBBBBB, 0, 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    drive(0, 32'h0, 32'h0, 0, 0);

    // Misaligned and aligned fetch addresses.
    drive(1, 32'hBFC00002, 32'hCCCCCCCC, 0, 0);
    drive(1, 32'hBFC00004, 32'hDDDDDDDD, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        pc = $urandom();
        if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
        drive(($urandom_range(0, 3) != 0), pc, $urandom(),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      end
    end

    for (int i = 0; i < 3; i++)
      drive(0, 32'h0, 32'h0, 1, 0);
    @(negedge clk);
    #1;
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 if_valid  input  1  fetch stage presents a fetched instruction this cycle.
REQ-005 if_pc  input  32  address of the fetched instruction.
REQ-006 if_pc4  input  32  if_pc + 4 as produced by fetch.
REQ-007 if_inst  input  32  fetched instruction word.
REQ-008 if_ready  output  1  buffer can accept an entry this cycle.
REQ-009 id_ready  input  1  decode consumes the head entry this cycle.
REQ-010 flush  input  1  discard all buffered entries (branch redirect or exception).
REQ-011 id_valid  output  1  head entry is valid.
REQ-012 id_pc, id_pc4, id_inst  output  32 each  head entry fields.
REQ-013 id_adel  output  1  head entry fetch address misaligned; present only with IFID_ADEL_EN.

Function
REQ-014 Storage SHALL be a 2-entry FIFO (main + skid); each entry holds pc, pc4, inst and, with IFID_ADEL_EN, the adel bit; occupancy count is 0..2.
REQ-015 if_ready SHALL be combinational: 1 when count < 2, 0 when count == 2.
REQ-016 Push occurs at a rising edge when if_valid && if_ready && !flush.
REQ-017 Pop occurs at a rising edge when id_valid && id_ready && !flush.
REQ-018 id_valid SHALL equal (count != 0); id_* SHALL be driven from the head entry, all-zero when count == 0.
REQ-019 Latency: an entry pushed at edge N SHALL appear on id_* after edge N if the FIFO was empty; otherwise behind older entries in order.
REQ-020 Push and pop at the same edge with count == 1 SHALL leave count 1 with the new entry at head; with count == 2 push is impossible (if_ready = 0).
REQ-021 Pop at count == 0 SHALL NOT occur (id_valid = 0); count SHALL never underflow or exceed 2.
REQ-022 flush SHALL take priority over push and pop: at the edge with flush = 1, count becomes 0 and both entries zeroed regardless of if_valid/id_ready.
REQ-023 Entry order SHALL be strict FIFO; read/write pointers are 1 bit and wrap 1 -> 0.
REQ-024 if_ready and id_valid SHALL NOT depend combinationally on each other or on id_ready (no combinational path if_* -> id_*).

Reset
REQ-025 resetn = 0 SHALL immediately set count = 0, pointers = 0, all entries = 0, giving id_valid = 0, id_* = 0, if_ready = 1.
REQ-026 Reset asserted mid-transfer SHALL drop all entries; the first push after resetn rises SHALL be the head.

Configuration
REQ-027 Macro IFID_ADEL_EN defined: adel = (if_pc[1:0] != 0) captured at push, forwarded on id_adel with its entry; entry otherwise treated normally.
REQ-028 Macro IFID_ADEL_EN undefined: id_adel port and adel storage SHALL NOT exist; all other behaviour identical.

Verification
REQ-029 Reset then if_valid = 1, if_pc = 0xBFC00000, if_inst = 0x24080001, id_ready = 1 -> next cycle id_valid = 1, id_pc = 0xBFC00000, id_pc4 = 0xBFC00004, id_inst = 0x24080001.
REQ-030 id_ready = 0, push 0xBFC00000 and 0xBFC00004 -> if_ready = 0 after second edge; third push ignored; id_ready = 1 yields both PCs in order, then id_valid = 0.
REQ-031 count = 2, flush = 1 with if_valid = 1 and id_ready = 1 -> next cycle id_valid = 0, id_* = 0, if_ready = 1.
REQ-032 count = 1, simultaneous push 0xBFC00008 and pop -> count stays 1, head pc = 0xBFC00008; continuous streaming with id_ready = 1 sustains one entry per cycle.
REQ-033 resetn pulsed low with count = 2 -> id_valid = 0 immediately without a clock edge; next push appears alone at head.
REQ-034 IFID_ADEL_EN defined, push if_pc = 0xBFC00002 -> id_adel = 1 with that entry; push 0xBFC00004 -> id_adel = 0.
